// File: rtl/fmul_pkg.sv
// fmul_pkg: constants and the s1->s2 side-band bundle shared by the FP multiplier stages.
// Default format constants describe fp16 (EXPWIDTH=5, PRECISION=11).
package fmul_pkg;

    localparam int EXPWIDTH_DEF  = 5;
    localparam int PRECISION_DEF = 11;
    localparam int BIASINT       = (1 << (EXPWIDTH_DEF - 1)) - 1;
    localparam int MAXNORMEXP    = (1 << EXPWIDTH_DEF) - 2;
    localparam int PADDINGBITS   = PRECISION_DEF + 2;

    // Fixed-width part of the stage-1 side band; exponent and tag widths are
    // per-instance parameters and travel next to this bundle.
    typedef struct packed {
        logic       special_valid;
        logic       special_nan;
        logic       special_inf;
        logic       special_inv;
        logic       special_haszero;
        logic       early_overflow;
        logic       prod_sign;
        logic       may_be_subnormal;
        logic [2:0] rm;
    } s1_side_t;

endpackage

// File: rtl/fmul_s2_if.sv
// fmul_s2_if: stage-2 upstream (in_*) and downstream (out_*) handshake plus data.
// slave = the multiplier stage, master = the surrounding pipeline / testbench.
interface fmul_s2_if #(
    parameter int EXPWIDTH  = 5,
    parameter int PRECISION = 11,
    parameter int TAG_WIDTH = 4
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [PRECISION-1:0]   in_a_sig_i;
    logic [PRECISION-1:0]   in_b_sig_i;
    logic                   in_special_valid_i;
    logic                   in_special_nan_i;
    logic                   in_special_inf_i;
    logic                   in_special_inv_i;
    logic                   in_special_haszero_i;
    logic                   in_early_overflow_i;
    logic                   in_prod_sign_i;
    logic [EXPWIDTH:0]      in_shift_amt_i;
    logic [EXPWIDTH:0]      in_exp_shifted_i;
    logic                   in_may_be_subnormal_i;
    logic [2:0]             in_rm_i;
    logic [TAG_WIDTH-1:0]   in_tag_i;

    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [2*PRECISION-1:0] out_sig_o;
    logic                   out_special_valid_o;
    logic                   out_special_nan_o;
    logic                   out_special_inf_o;
    logic                   out_special_inv_o;
    logic                   out_special_haszero_o;
    logic                   out_early_overflow_o;
    logic                   out_prod_sign_o;
    logic [EXPWIDTH:0]      out_exp_shifted_o;
    logic                   out_may_be_subnormal_o;
    logic [2:0]             out_rm_o;
    logic [TAG_WIDTH-1:0]   out_tag_o;

    modport slave (
        input  in_valid_i, in_a_sig_i, in_b_sig_i, in_special_valid_i, in_special_nan_i,
               in_special_inf_i, in_special_inv_i, in_special_haszero_i, in_early_overflow_i,
               in_prod_sign_i, in_shift_amt_i, in_exp_shifted_i, in_may_be_subnormal_i,
               in_rm_i, in_tag_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sig_o, out_special_valid_o, out_special_nan_o,
               out_special_inf_o, out_special_inv_o, out_special_haszero_o, out_early_overflow_o,
               out_prod_sign_o, out_exp_shifted_o, out_may_be_subnormal_o, out_rm_o, out_tag_o
    );

    modport master (
        output in_valid_i, in_a_sig_i, in_b_sig_i, in_special_valid_i, in_special_nan_i,
               in_special_inf_i, in_special_inv_i, in_special_haszero_i, in_early_overflow_i,
               in_prod_sign_i, in_shift_amt_i, in_exp_shifted_i, in_may_be_subnormal_i,
               in_rm_i, in_tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sig_o, out_special_valid_o, out_special_nan_o,
               out_special_inf_o, out_special_inv_o, out_special_haszero_o, out_early_overflow_o,
               out_prod_sign_o, out_exp_shifted_o, out_may_be_subnormal_o, out_rm_o, out_tag_o
    );
endinterface

// File: rtl/fmul_pipe_reg.sv
// fmul_pipe_reg: one valid/ready pipeline slot of WIDTH bits with flush.
// Accepts when empty or when the held word leaves in the same cycle (no bubble).
module fmul_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             in_fire;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next state: data loads on accept only; flush kills the slot (data is don't-care then).
    always_comb begin
        in_fire = in_valid_i && in_ready_o;
        data_d  = in_fire ? in_data_i : data_q;
        valid_d = in_fire || (valid_q && !out_ready_i);
        if (flush_i) valid_d = 1'b0;
    end

    // Slot registers, synchronous reset clears valid and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/fmul_s2.sv
// fmul_s2: FP multiplier stage 2 - significand product, left-normalised by the
// stage-1 shift amount, with side-band pass-through and valid/ready/flush.
// Option macro FMUL_S2_MUL_PIPE_EN: split into product stage A and shift stage B
// (latency 2, still one op per cycle). Undefined: single stage, latency 1.
module fmul_s2
    import fmul_pkg::*;
#(
    parameter int EXPWIDTH  = 5,
    parameter int PRECISION = 11,
    parameter int TAG_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    fmul_s2_if.slave   bus
);
    localparam int SIGW = 2 * PRECISION;

    typedef struct packed {
        s1_side_t             side;
        logic [EXPWIDTH:0]    exp;
        logic [TAG_WIDTH-1:0] tag;
        logic [SIGW-1:0]      sig;
    } s2_word_t;

    s1_side_t        in_side;
    logic [SIGW-1:0] prod;
    s2_word_t        out_word;

    // Gather side band and form the full-width unsigned significand product.
    always_comb begin
        in_side.special_valid    = bus.in_special_valid_i;
        in_side.special_nan      = bus.in_special_nan_i;
        in_side.special_inf      = bus.in_special_inf_i;
        in_side.special_inv      = bus.in_special_inv_i;
        in_side.special_haszero  = bus.in_special_haszero_i;
        in_side.early_overflow   = bus.in_early_overflow_i;
        in_side.prod_sign        = bus.in_prod_sign_i;
        in_side.may_be_subnormal = bus.in_may_be_subnormal_i;
        in_side.rm               = bus.in_rm_i;
        prod = {{PRECISION{1'b0}}, bus.in_a_sig_i} * {{PRECISION{1'b0}}, bus.in_b_sig_i};
    end

`ifdef FMUL_S2_MUL_PIPE_EN
    typedef struct packed {
        s1_side_t             side;
        logic [EXPWIDTH:0]    exp;
        logic [TAG_WIDTH-1:0] tag;
        logic [EXPWIDTH:0]    shift;
        logic [SIGW-1:0]      prod;
    } s2a_word_t;

    s2a_word_t a_in, a_out;
    s2_word_t  b_in;
    logic      a_valid, b_ready;

    // Stage A captures the raw product; stage B applies the shift. A logical
    // shift by >= SIGW already yields zero, and bits above the MSB are dropped.
    always_comb begin
        a_in     = '{side: in_side, exp: bus.in_exp_shifted_i, tag: bus.in_tag_i,
                     shift: bus.in_shift_amt_i, prod: prod};
        b_in     = '{side: a_out.side, exp: a_out.exp, tag: a_out.tag,
                     sig: a_out.prod << a_out.shift};
    end

    fmul_pipe_reg #(.WIDTH($bits(s2a_word_t))) u_stage_a (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(bus.in_valid_i), .in_ready_o(bus.in_ready_o), .in_data_i(a_in),
        .out_valid_o(a_valid), .out_ready_i(b_ready), .out_data_o(a_out)
    );

    fmul_pipe_reg #(.WIDTH($bits(s2_word_t))) u_stage_b (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(a_valid), .in_ready_o(b_ready), .in_data_i(b_in),
        .out_valid_o(bus.out_valid_o), .out_ready_i(bus.out_ready_i), .out_data_o(out_word)
    );
`else
    s2_word_t in_word;

    // Shift and register in one step; shift >= SIGW gives zero by shift semantics.
    always_comb begin
        in_word = '{side: in_side, exp: bus.in_exp_shifted_i, tag: bus.in_tag_i,
                    sig: prod << bus.in_shift_amt_i};
    end

    fmul_pipe_reg #(.WIDTH($bits(s2_word_t))) u_stage (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(bus.in_valid_i), .in_ready_o(bus.in_ready_o), .in_data_i(in_word),
        .out_valid_o(bus.out_valid_o), .out_ready_i(bus.out_ready_i), .out_data_o(out_word)
    );
`endif

    assign bus.out_sig_o              = out_word.sig;
    assign bus.out_exp_shifted_o      = out_word.exp;
    assign bus.out_tag_o              = out_word.tag;
    assign bus.out_special_valid_o    = out_word.side.special_valid;
    assign bus.out_special_nan_o      = out_word.side.special_nan;
    assign bus.out_special_inf_o      = out_word.side.special_inf;
    assign bus.out_special_inv_o      = out_word.side.special_inv;
    assign bus.out_special_haszero_o  = out_word.side.special_haszero;
    assign bus.out_early_overflow_o   = out_word.side.early_overflow;
    assign bus.out_prod_sign_o        = out_word.side.prod_sign;
    assign bus.out_may_be_subnormal_o = out_word.side.may_be_subnormal;
    assign bus.out_rm_o               = out_word.side.rm;
endmodule

// File: tb/tb_fmul_s2.sv
// tb_fmul_s2: directed plus randomized checks of fmul_s2 against an arithmetic
// reference model and an in-order expected-output queue.
module tb_fmul_s2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        logic [21:0] sig;
        logic [20:0] side;
    } exp_t;
    exp_t sbq[$];

    fmul_s2_if #(.EXPWIDTH(5), .PRECISION(11), .TAG_WIDTH(4)) bus ();

    fmul_s2 #(.EXPWIDTH(5), .PRECISION(11), .TAG_WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: full product, shifted left, kept to 22 bits.
    function automatic logic [21:0] ref_sig(input logic [10:0] a, input logic [10:0] b,
                                            input logic [5:0] sh);
        longint unsigned p;
        longint unsigned r;
        p = longint'(a) * longint'(b);
        if (sh >= 6'd22) return 22'h0;
        r = p << sh;
        return r[21:0];
    endfunction

    function automatic logic [20:0] in_side();
        return {bus.in_special_valid_i, bus.in_special_nan_i, bus.in_special_inf_i,
                bus.in_special_inv_i, bus.in_special_haszero_i, bus.in_early_overflow_i,
                bus.in_prod_sign_i, bus.in_may_be_subnormal_i, bus.in_rm_i,
                bus.in_exp_shifted_i, bus.in_tag_i};
    endfunction

    function automatic logic [20:0] out_side();
        return {bus.out_special_valid_o, bus.out_special_nan_o, bus.out_special_inf_o,
                bus.out_special_inv_o, bus.out_special_haszero_o, bus.out_early_overflow_o,
                bus.out_prod_sign_o, bus.out_may_be_subnormal_o, bus.out_rm_o,
                bus.out_exp_shifted_o, bus.out_tag_o};
    endfunction

    task automatic drive(input logic [10:0] a, input logic [10:0] b, input logic [5:0] sh,
                         input logic [5:0] ex, input logic [2:0] rm, input logic [3:0] tag,
                         input logic [7:0] fl);
        bus.in_a_sig_i            = a;
        bus.in_b_sig_i            = b;
        bus.in_shift_amt_i        = sh;
        bus.in_exp_shifted_i      = ex;
        bus.in_rm_i               = rm;
        bus.in_tag_i              = tag;
        bus.in_special_valid_i    = fl[7];
        bus.in_special_nan_i      = fl[6];
        bus.in_special_inf_i      = fl[5];
        bus.in_special_inv_i      = fl[4];
        bus.in_special_haszero_i  = fl[3];
        bus.in_early_overflow_i   = fl[2];
        bus.in_prod_sign_i        = fl[1];
        bus.in_may_be_subnormal_i = fl[0];
        bus.in_valid_i            = 1'b1;
    endtask

    // Scoreboard: every valid output must match the oldest accepted op; reset
    // and flush drop everything in flight including the op offered that cycle.
    always @(negedge clk) begin
        if (mon_en) begin
`ifndef FMUL_S2_MUL_PIPE_EN
            chk("in_ready_rule", 64'(bus.in_ready_o), 64'(!bus.out_valid_o || bus.out_ready_i));
`endif
            if (!rst && !flush && bus.out_valid_o) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 64'(bus.out_valid_o), 64'd0);
                end else begin
                    chk("sig", 64'(bus.out_sig_o), 64'(sbq[0].sig));
                    chk("side", 64'(out_side()), 64'(sbq[0].side));
                    if (bus.out_ready_i) void'(sbq.pop_front());
                end
            end
            if (rst || flush) sbq.delete();
            else if (bus.in_valid_i && bus.in_ready_o) begin
                exp_t e;
                e.sig  = ref_sig(bus.in_a_sig_i, bus.in_b_sig_i, bus.in_shift_amt_i);
                e.side = in_side();
                sbq.push_back(e);
            end
        end
    end

    initial begin
        bus.out_ready_i = 1'b1;
        drive(11'h0, 11'h0, 6'd0, 6'd0, 3'd0, 4'd0, 8'h0);
        bus.in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_sig", 64'(bus.out_sig_o), 64'd0);
        chk("rst_side", 64'(out_side()), 64'd0);
        chk("rst_ready", 64'(bus.in_ready_o), 64'd1);

        // 1.5 * 1.5, latency 1
        @(posedge clk); #1 drive(11'h600, 11'h600, 6'd0, 6'd15, 3'd0, 4'd1, 8'h00);
        @(posedge clk); #1 bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("mul15_valid", 64'(bus.out_valid_o), 64'd1);
        chk("mul15_sig", 64'(bus.out_sig_o), 64'h240000);

        // Subnormal operand with large normalising shift
        @(posedge clk); #1 drive(11'h001, 11'h400, 6'd10, 6'd1, 3'd4, 4'hA, 8'h01);
        @(posedge clk); #1 bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("sub_sig", 64'(bus.out_sig_o), 64'h100000);
        chk("sub_exp", 64'(bus.out_exp_shifted_o), 64'd1);
        chk("sub_rm", 64'(bus.out_rm_o), 64'd4);
        chk("sub_tag", 64'(bus.out_tag_o), 64'hA);

        // Stall: first op held, second waits, order kept
        @(posedge clk); #1 begin bus.out_ready_i = 1'b0; drive(11'h555, 11'h7FF, 6'd3, 6'd9, 3'd1, 4'd1, 8'h12); end
        @(posedge clk); #1 drive(11'h432, 11'h6AB, 6'd1, 6'd7, 3'd2, 4'd2, 8'h80);
        @(negedge clk);
        chk("stall_valid", 64'(bus.out_valid_o), 64'd1);
        chk("stall_tag", 64'(bus.out_tag_o), 64'd1);
        chk("stall_ready", 64'(bus.in_ready_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_hold_tag", 64'(bus.out_tag_o), 64'd1);
        chk("stall_hold_sig", 64'(bus.out_sig_o), 64'(ref_sig(11'h555, 11'h7FF, 6'd3)));
        chk("stall_hold_ready", 64'(bus.in_ready_o), 64'd0);
        @(posedge clk); #1 bus.out_ready_i = 1'b1;
        @(posedge clk); #1 bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("stall_second_tag", 64'(bus.out_tag_o), 64'd2);
        chk("stall_second_valid", 64'(bus.out_valid_o), 64'd1);

        // Back-to-back 8 ops, no bubbles
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i < 8) drive(11'($urandom), 11'($urandom), 6'($urandom_range(0, 11)), 6'(i), 3'd0, 4'(i), 8'h0);
            else bus.in_valid_i = 1'b0;
            if (i > 0) begin
                @(negedge clk);
                chk("b2b_valid", 64'(bus.out_valid_o), 64'd1);
                chk("b2b_tag", 64'(bus.out_tag_o), 64'(i - 1));
            end
        end

        // Flush with a held output and an accept in the same cycle
        @(posedge clk); #1 begin bus.out_ready_i = 1'b0; drive(11'h3FF, 11'h3FF, 6'd0, 6'd5, 3'd0, 4'hC, 8'h0); end
        @(posedge clk); #1 begin bus.out_ready_i = 1'b1; flush = 1'b1; drive(11'h111, 11'h222, 6'd0, 6'd6, 3'd0, 4'hD, 8'h0); end
        @(posedge clk); #1 begin flush = 1'b0; bus.in_valid_i = 1'b0; end
        @(negedge clk);
        chk("flush_valid", 64'(bus.out_valid_o), 64'd0);
        repeat (3) @(negedge clk);
        chk("flush_stays_empty", 64'(bus.out_valid_o), 64'd0);

        // Reset in the middle of a stall
        @(posedge clk); #1 begin bus.out_ready_i = 1'b0; drive(11'h7AB, 11'h5CD, 6'd2, 6'd3, 3'd3, 4'h5, 8'hFF); end
        @(posedge clk); #1 bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus.out_valid_o), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("midrst_sig", 64'(bus.out_sig_o), 64'd0);
        chk("midrst_ready", 64'(bus.in_ready_o), 64'd1);

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            drive(11'($urandom), 11'($urandom), 6'($urandom_range(0, 31)), 6'($urandom),
                  3'($urandom), 4'($urandom), 8'($urandom));
            bus.in_valid_i  = ($urandom_range(0, 3) != 0);
            bus.out_ready_i = ($urandom_range(0, 9) < 7);
            flush           = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #1 begin bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1; flush = 1'b0; end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
